serial_adder_sub: RTL
=====================

SERIAL_ADDER_SUB -- requirements
Module: serial_adder_sub

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits, legal range 1..64.
REQ-002 The block SHALL have these ports, each listed as name, direction, width, meaning:
- CLK  input  1  the single clock; all state updates on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- Start  input  1  request a new operation; sampled on the CLK rising edge.
- A  input  WIDTH  operand A, captured when Start is accepted.
- B  input  WIDTH  operand B, captured when Start is accepted.
- Cin  input  1  carry-in (add) or borrow-in (subtract), captured when Start is accepted.
- Sub  input  1  0 = add, 1 = subtract; captured when Start is accepted.
- S  output  WIDTH  registered result.
- Cout  output  1  registered raw carry out of the MSB.
- Ovf  output  1  registered two's-complement overflow.
- Zero  output  1  registered flag, set when S is 0.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle completion pulse.
REQ-003 The block SHALL use one clock, CLK; reset SHALL be asynchronous and active-low on RST_N.

Function
REQ-004 The FSM SHALL have two states: IDLE and RUN.
REQ-005 In IDLE, when Start=1, the block SHALL accept the operation on that edge:
- latch A;
- latch B XOR {WIDTH{Sub}};
- set the carry register to Cin XOR Sub;
- clear the bit counter to 0;
- enter RUN.
REQ-006 In RUN, the block SHALL process one bit per cycle, LSB first, using a 1-bit full-adder slice:
- sum bit = a ^ b ^ c;
- carry = (a&b) | (a&c) | (b&c);
- the sum bit goes into an internal shift register;
- the carry register updates on each edge.
REQ-007 RUN SHALL last exactly WIDTH cycles.
- If Start is accepted at edge N, bit i (i = 0..WIDTH-1) SHALL be processed at edge N+1+i.
- At edge N+WIDTH, S, Cout, Ovf and Zero SHALL update together.
- At that same edge, Busy SHALL fall, Done SHALL rise for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-008 The arithmetic SHALL be:
- Add: S = (A + B + Cin) mod 2^WIDTH.
- Subtract: S = (A - B - Cin) mod 2^WIDTH.
- Cout SHALL be the raw carry out of bit WIDTH-1. For subtract, Cout=1 means no borrow.
REQ-009 Ovf SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1). For WIDTH=1, the carry into bit 0 is the initial carry.
REQ-010 Zero SHALL be 1 when the final S is 0, otherwise 0.
REQ-011 Busy SHALL be 1 exactly while the FSM is in RUN.
REQ-012 Start asserted while Busy=1 SHALL be ignored. No queuing; the operands and the in-flight result SHALL be unaffected.
REQ-013 Start asserted in the same cycle that Done=1 SHALL be accepted. Back-to-back operations therefore complete every WIDTH+1 cycles.
REQ-014 S, Cout, Ovf and Zero SHALL hold their last completed values until the next completion. Partial results SHALL never appear on these outputs.
REQ-015 A, B, Cin and Sub changing after acceptance SHALL not affect the operation in progress.

Reset
REQ-016 While RST_N=0, the block SHALL asynchronously force the following, regardless of CLK:
- FSM = IDLE;
- S = 0, Cout = 0, Ovf = 0;
- Zero = 1, consistent with S = 0;
- Busy = 0, Done = 0;
- internal shift register, carry register and counter = 0.
REQ-017 Reset asserted mid-operation SHALL abort the operation with no Done pulse. The first Start after RST_N deasserts SHALL be handled normally.

Verification
REQ-018 All scenarios below use WIDTH=8 unless stated.
REQ-019 Add overflow: A=0x7F, B=0x01, Cin=0, Sub=0, Start at edge N -> at edge N+8: S=0x80, Cout=0, Ovf=1, Zero=0, Done=1 for one cycle; Busy high from N through N+8.
REQ-020 Add wrap: A=0xFF, B=0x01, Cin=0, Sub=0 -> S=0x00, Cout=1, Ovf=0, Zero=1.
REQ-021 Subtract with borrow: A=0x05, B=0x07, Cin=0, Sub=1 -> S=0xFE, Cout=0, Ovf=0, Zero=0. Second case, Cin=1: A=0x80, B=0x00, Sub=1 -> S=0x7F, Cout=1, Ovf=1.
REQ-022 Start while busy: start A=0x10, B=0x20 add. Pulse Start at N+3 with A=0xFF, B=0xFF -> at N+8: S=0x30, exactly one Done, no second operation.
REQ-023 Reset mid-run, then back-to-back: assert RST_N=0 at N+4 -> outputs immediately return to reset values, no Done. Then issue two operations, the second with Start held during the first Done -> the second Done arrives 9 cycles after the first.
REQ-024 Parameter sweep: WIDTH=1 and WIDTH=64 with random operands against a reference model -> S, Cout, Ovf and Zero match, with latency equal to WIDTH.

Source files
------------

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor.
// Each accepted operation ripples one bit per clock through a single
// full-adder slice, LSB first, and publishes S/Cout/Ovf/Zero all at once
// on the final bit so that partial results are never visible.
module serial_adder_sub #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aReg_q, aReg_d;
  logic [WIDTH-1:0] bReg_q, bReg_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic             sumBit;
  logic             carryOut;
  logic [WIDTH:0]   shiftWide;

  // Full-adder slice on the current LSBs of the operand registers; the new
  // sum bit enters the shift register from the top so bit 0 ends up at S[0].
  always_comb begin
    sumBit    = aReg_q[0] ^ bReg_q[0] ^ carry_q;
    carryOut  = (aReg_q[0] & bReg_q[0]) | (aReg_q[0] & carry_q) | (bReg_q[0] & carry_q);
    shiftWide = {sumBit, shift_q};
  end

  // Next-state logic: accept in IDLE (B is pre-inverted and the carry seeded
  // for subtraction), one bit per cycle in RUN, publish on the last bit.
  always_comb begin
    state_d = state_q;
    aReg_d  = aReg_q;
    bReg_d  = bReg_q;
    shift_d = shift_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          aReg_d  = A;
          bReg_d  = B ^ {WIDTH{Sub}};
          carry_d = Cin ^ Sub;
          cnt_d   = '0;
          shift_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        shift_d = shiftWide[WIDTH:1];
        aReg_d  = aReg_q >> 1;
        bReg_d  = bReg_q >> 1;
        carry_d = carryOut;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          sum_d   = shiftWide[WIDTH:1];
          cout_d  = carryOut;
          ovf_d   = carry_q ^ carryOut;
          zero_d  = (shiftWide[WIDTH:1] == '0);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset leaves the result reading as zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      aReg_q  <= '0;
      bReg_q  <= '0;
      shift_q <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      aReg_q  <= aReg_d;
      bReg_q  <= bReg_d;
      shift_q <= shift_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign S    = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
  assign Zero = zero_q;
  assign Done = done_q;
  assign Busy = (state_q == RUN);

endmodule
